// File: rtl/variable_delay_ctrl_pkg.sv
// Shared types and helpers for the variable-delay sequencer: FSM states,
// per-state output decode and counter sizing.
package variable_delay_pkg;

    localparam int DELAY_W = 7;
    localparam int CNT_W   = DELAY_W + 2;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic cfg_ready;
        logic locked;
        logic busy;
        logic dly_resetn;
        logic fifo_rst;
    } ctrl_outs_t;

    // Outputs are registered alongside the state, so decode from the state being entered.
    function automatic ctrl_outs_t state_outs(input ctrl_state_t s);
        ctrl_outs_t o;
        o.cfg_ready  = (s == RUN) || (s == FAULT);
        o.locked     = (s == RUN);
        o.busy       = (s == FLUSH) || (s == FILL);
        o.dly_resetn = (s != FLUSH);
        o.fifo_rst   = (s == FLUSH);
        return o;
    endfunction

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/variable_delay_ctrl_if.sv
// Config handshake, delay-module/FIFO control and status bundle of the sequencer.
// slave = sequencer side, master = the environment driving configs and the delay line.
interface variable_delay_ctrl_if
    import variable_delay_pkg::*;
#(
    parameter int MAX_DELAY_CNT_WIDTH = DELAY_W
);
    logic [MAX_DELAY_CNT_WIDTH-1:0] CFG_DELAY;
    logic                           CFG_VALID;
    logic                           CFG_READY;
    logic                           DLY_RESETN;
    logic [MAX_DELAY_CNT_WIDTH-1:0] DLY_DELAY;
    logic                           FIFO_RST;
    logic                           DLY_READY;
    logic                           DLY_VALID;
    logic                           FIFO_FULL;
    logic                           OUT_VALID;
    logic                           LOCKED;
    logic                           BUSY;
    logic                           ERR_TIMEOUT;
    logic                           ERR_OVERFLOW;

    modport slave (
        input  CFG_DELAY, CFG_VALID, DLY_READY, DLY_VALID, FIFO_FULL,
        output CFG_READY, DLY_RESETN, DLY_DELAY, FIFO_RST,
               OUT_VALID, LOCKED, BUSY, ERR_TIMEOUT, ERR_OVERFLOW
    );

    modport master (
        output CFG_DELAY, CFG_VALID, DLY_READY, DLY_VALID, FIFO_FULL,
        input  CFG_READY, DLY_RESETN, DLY_DELAY, FIFO_RST,
               OUT_VALID, LOCKED, BUSY, ERR_TIMEOUT, ERR_OVERFLOW
    );
endinterface

// File: rtl/variable_delay_ctrl_timer.sv
// delay_cycle_timer: up-counter with synchronous clear/load and a terminal-count
// compare; times both the flush hold and the refill window.
module delay_cycle_timer
    import variable_delay_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_W
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic                 clr,
    input  logic                 load,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic [CNT_WIDTH-1:0] term_val,
    output logic                 at_term
);
    logic [CNT_WIDTH-1:0] cnt_reg;

    always_ff @(posedge CLK) begin
        if (!RESETN || clr) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign at_term = (cnt_reg == term_val);
endmodule

// File: rtl/variable_delay_ctrl.sv
// Flush/refill sequencer for a variable delay line and its FIFO.
// Optional macro VARIABLE_DELAY_CTRL_CLAMP_EN clamps oversize delay requests to MAX_DELAY.
module variable_delay_ctrl
    import variable_delay_pkg::*;
#(
    parameter int MAX_DELAY_CNT_WIDTH = DELAY_W,
    parameter int DEFAULT_DELAY       = 0,
    parameter int MAX_DELAY           = 100,
    parameter int FLUSH_CYCLES        = 4,
    parameter int FILL_MARGIN         = 8
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    variable_delay_ctrl_if.slave bus
);
    localparam int W     = MAX_DELAY_CNT_WIDTH;
    localparam int LIM_W = W + 2;
    localparam int FL_W  = clogb2(FLUSH_CYCLES) + 1;
    localparam int CTR_W = (LIM_W > FL_W) ? LIM_W : FL_W;

    ctrl_state_t      state_reg;
    ctrl_outs_t       outs_reg;
    logic [W-1:0]     dly_delay_reg;
    logic             err_timeout_reg;
    logic             err_overflow_reg;

    logic [LIM_W-1:0] fill_limit;
    logic [CTR_W-1:0] term_val;
    logic             at_term;
    logic             tmr_clr;
    logic             tmr_load;
    logic             tmr_en;
    logic             accept;
    logic             too_big;
    logic             take;
    logic [W-1:0]     new_delay;
    logic             unused_dly_ready;

    assign unused_dly_ready = bus.DLY_READY;

    // Widened by two bits so DLY_DELAY + margin never wraps.
    assign fill_limit = LIM_W'(dly_delay_reg) + LIM_W'(FILL_MARGIN + 2);
    assign accept     = outs_reg.cfg_ready && bus.CFG_VALID;
    assign too_big    = bus.CFG_DELAY > W'(MAX_DELAY);

`ifdef VARIABLE_DELAY_CTRL_CLAMP_EN
    assign take      = accept;
    assign new_delay = too_big ? W'(MAX_DELAY) : bus.CFG_DELAY;
`else
    assign take      = accept && !too_big;
    assign new_delay = bus.CFG_DELAY;
`endif

    // FILL ends on the cycle the running count would reach the limit.
    always_comb begin
        tmr_clr  = 1'b0;
        tmr_load = take;
        tmr_en   = 1'b0;
        term_val = CTR_W'(FLUSH_CYCLES - 1);
        case (state_reg)
            FLUSH: begin
                tmr_clr = at_term;
                tmr_en  = 1'b1;
            end
            FILL: begin
                term_val = CTR_W'(fill_limit - 1'b1);
                tmr_en   = 1'b1;
            end
            default: begin
                tmr_en = 1'b0;
            end
        endcase
    end

    delay_cycle_timer #(
        .CNT_WIDTH (CTR_W)
    ) u_timer (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val ('0),
        .term_val (term_val),
        .at_term  (at_term)
    );

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_reg        <= FLUSH;
            outs_reg         <= state_outs(FLUSH);
            dly_delay_reg    <= W'(DEFAULT_DELAY);
            err_timeout_reg  <= 1'b0;
            err_overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                FLUSH: begin
                    if (at_term) begin
                        state_reg <= FILL;
                        outs_reg  <= state_outs(FILL);
                    end
                end
                FILL: begin
                    if (bus.DLY_VALID) begin
                        state_reg <= RUN;
                        outs_reg  <= state_outs(RUN);
                    end else if (at_term) begin
                        err_timeout_reg <= 1'b1;
                        state_reg       <= FAULT;
                        outs_reg        <= state_outs(FAULT);
                    end
                end
                default: begin
                    // An oversize request that is dropped still blocks the overflow update.
                    if (take) begin
                        dly_delay_reg    <= new_delay;
                        err_timeout_reg  <= 1'b0;
                        err_overflow_reg <= 1'b0;
                        state_reg        <= FLUSH;
                        outs_reg         <= state_outs(FLUSH);
                    end else if (!accept && state_reg == RUN && bus.FIFO_FULL) begin
                        err_overflow_reg <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.CFG_READY    = outs_reg.cfg_ready;
    assign bus.LOCKED       = outs_reg.locked;
    assign bus.BUSY         = outs_reg.busy;
    assign bus.DLY_RESETN   = outs_reg.dly_resetn;
    assign bus.FIFO_RST     = outs_reg.fifo_rst;
    assign bus.DLY_DELAY    = dly_delay_reg;
    assign bus.ERR_TIMEOUT  = err_timeout_reg;
    assign bus.ERR_OVERFLOW = err_overflow_reg;
    assign bus.OUT_VALID    = bus.DLY_VALID && outs_reg.locked;
endmodule

// File: tb/tb_variable_delay_ctrl.sv
// Bench for variable_delay_ctrl: delay-line model, per-cycle reference model and
// directed scenarios with hand-computed latencies.
`timescale 1ns/1ps
module tb_variable_delay_ctrl;
    localparam int W             = 7;
    localparam int DEFAULT_DELAY = 0;
    localparam int MAX_DELAY     = 100;
    localparam int FLUSH_CYCLES  = 4;
    localparam int FILL_MARGIN   = 8;
`ifdef VARIABLE_DELAY_CTRL_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
`else
    localparam bit CLAMP_ON = 1'b0;
`endif
    localparam int PH_FLUSH = 10, PH_FILL = 11, PH_RUN = 12, PH_FAULT = 13;

    logic CLK    = 1'b0;
    logic RESETN = 1'b0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n;

    variable_delay_ctrl_if #(.MAX_DELAY_CNT_WIDTH(W)) bus();

    variable_delay_ctrl #(
        .MAX_DELAY_CNT_WIDTH (W),
        .DEFAULT_DELAY       (DEFAULT_DELAY),
        .MAX_DELAY           (MAX_DELAY),
        .FLUSH_CYCLES        (FLUSH_CYCLES),
        .FILL_MARGIN         (FILL_MARGIN)
    ) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    // Delay-line model: first valid output D+1 cycles after its reset releases.
    int   dm_cnt = 0;
    logic dm_en  = 1'b1;
    always @(posedge CLK) begin
        if (!bus.DLY_RESETN) dm_cnt <= 0;
        else if (dm_cnt < 1000) dm_cnt <= dm_cnt + 1;
    end
    assign bus.DLY_VALID = dm_en && bus.DLY_RESETN && (dm_cnt >= int'(bus.DLY_DELAY) + 1);
    assign bus.DLY_READY = bus.DLY_RESETN;

    // Reference model: phase plus cycles spent in it.
    int m_phase = PH_FLUSH;
    int m_age   = 0;
    int m_delay = DEFAULT_DELAY;
    bit m_tout  = 1'b0;
    bit m_ovf   = 1'b0;
    bit m_live  = 1'b0;

    always @(posedge CLK) begin
        if (!RESETN) begin
            m_live  <= 1'b1;
            m_phase <= PH_FLUSH;
            m_age   <= 0;
            m_delay <= DEFAULT_DELAY;
            m_tout  <= 1'b0;
            m_ovf   <= 1'b0;
        end else if (m_live) begin
            if (m_phase == PH_FLUSH) begin
                if (m_age == FLUSH_CYCLES - 1) begin
                    m_phase <= PH_FILL;
                    m_age   <= 0;
                end else begin
                    m_age <= m_age + 1;
                end
            end else if (m_phase == PH_FILL) begin
                if (bus.DLY_VALID) begin
                    m_phase <= PH_RUN;
                end else if (m_age + 1 == m_delay + FILL_MARGIN + 2) begin
                    m_phase <= PH_FAULT;
                    m_tout  <= 1'b1;
                end else begin
                    m_age <= m_age + 1;
                end
            end else if (bus.CFG_VALID) begin
                if (int'(bus.CFG_DELAY) <= MAX_DELAY || CLAMP_ON) begin
                    m_delay <= (int'(bus.CFG_DELAY) > MAX_DELAY) ? MAX_DELAY : int'(bus.CFG_DELAY);
                    m_tout  <= 1'b0;
                    m_ovf   <= 1'b0;
                    m_phase <= PH_FLUSH;
                    m_age   <= 0;
                end
            end else if (m_phase == PH_RUN && bus.FIFO_FULL) begin
                m_ovf <= 1'b1;
            end
        end
    end

    logic [W+7:0] exp_v;
    logic [W+7:0] act_v;
    initial begin
        forever begin
            @(negedge CLK);
            if (m_live) begin
                act_v = {bus.CFG_READY, bus.LOCKED, bus.BUSY, bus.DLY_RESETN, bus.FIFO_RST,
                         bus.OUT_VALID, bus.ERR_TIMEOUT, bus.ERR_OVERFLOW, bus.DLY_DELAY};
                exp_v = {(m_phase == PH_RUN) || (m_phase == PH_FAULT), m_phase == PH_RUN,
                         (m_phase == PH_FLUSH) || (m_phase == PH_FILL), m_phase != PH_FLUSH,
                         m_phase == PH_FLUSH, bus.DLY_VALID && (m_phase == PH_RUN),
                         m_tout, m_ovf, W'(m_delay)};
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_bad++;
                    $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, act_v, exp_v);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       return bus.DLY_RESETN;
            1:       return bus.LOCKED;
            default: return bus.ERR_TIMEOUT;
        endcase
    endfunction

    // Called at a negedge; counts negedges until the probed signal is 1 (bounded).
    task automatic count_until(input int sel, input int bound, output int cnt);
        cnt = 0;
        while (probe(sel) !== 1'b1 && cnt < bound) begin
            @(negedge CLK);
            cnt++;
        end
    endtask

    task automatic send_cfg(input int d);
        bus.CFG_DELAY = W'(d);
        bus.CFG_VALID = 1'b1;
        @(posedge CLK);
        #1;
        bus.CFG_VALID = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.CFG_VALID = 1'b0;
        bus.CFG_DELAY = '0;
        bus.FIFO_FULL = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_dly_resetn", bus.DLY_RESETN, 0);
        check("rst_fifo_rst", bus.FIFO_RST, 1);
        check("rst_cfg_ready", bus.CFG_READY, 0);
        check("rst_locked", bus.LOCKED, 0);
        check("rst_delay", bus.DLY_DELAY, DEFAULT_DELAY);
        check("rst_errs", {bus.ERR_TIMEOUT, bus.ERR_OVERFLOW}, 0);
        RESETN = 1'b1;

        // Power-up with delay 0.
        @(negedge CLK);
        count_until(0, 50, n);  check("pwr_flush_len", n, 4);
        count_until(1, 50, n);  check("pwr_lock_lat", n, 2);
        check("pwr_out_valid", bus.OUT_VALID, 1);
        check("pwr_errs", {bus.ERR_TIMEOUT, bus.ERR_OVERFLOW}, 0);

        // Delay 20; a request for 5 is then held through FILL.
        send_cfg(20);
        check("cfg20_ready_drop", bus.CFG_READY, 0);
        check("cfg20_delay", bus.DLY_DELAY, 20);
        check("cfg20_out_valid", bus.OUT_VALID, 0);
        @(negedge CLK);
        count_until(0, 50, n);  check("cfg20_flush_len", n, 4);
        bus.CFG_DELAY = 7'd5;
        bus.CFG_VALID = 1'b1;
        check("fill_ready_low", bus.CFG_READY, 0);
        count_until(1, 60, n);  check("cfg20_lock_lat", n, 22);
        check("run_first_ready", bus.CFG_READY, 1);
        check("run_first_delay", bus.DLY_DELAY, 20);
        @(posedge CLK);
        #1;
        bus.CFG_VALID = 1'b0;
        check("held_cfg_delay", bus.DLY_DELAY, 5);
        check("held_cfg_busy", bus.BUSY, 1);
        @(negedge CLK);
        count_until(0, 50, n);  check("cfg5_flush_len", n, 4);
        count_until(1, 50, n);  check("cfg5_lock_lat", n, 7);

        // Delay line never answers: timeout after 10+8+2 FILL cycles.
        send_cfg(10);
        dm_en = 1'b0;
        @(negedge CLK);
        count_until(0, 50, n);  check("tmo_flush_len", n, 4);
        count_until(2, 60, n);  check("tmo_fill_cycles", n, 20);
        check("tmo_locked", bus.LOCKED, 0);
        check("tmo_ready", bus.CFG_READY, 1);
        check("tmo_dly_resetn", bus.DLY_RESETN, 1);
        @(posedge CLK);
        #1;
        dm_en = 1'b1;
        send_cfg(3);
        check("tmo_cleared", bus.ERR_TIMEOUT, 0);
        check("tmo_new_delay", bus.DLY_DELAY, 3);
        @(negedge CLK);
        count_until(0, 50, n);  check("cfg3_flush_len", n, 4);
        count_until(1, 50, n);  check("cfg3_lock_lat", n, 5);

        // Oversize request.
        send_cfg(120);
        check("big_delay", bus.DLY_DELAY, CLAMP_ON ? MAX_DELAY : 3);
        check("big_locked", bus.LOCKED, CLAMP_ON ? 0 : 1);
        @(negedge CLK);
        count_until(1, 200, n); check("big_relock_lat", n, CLAMP_ON ? 4 + MAX_DELAY + 2 : 0);

        // Overflow is sticky; a handshake beats a simultaneous FIFO_FULL.
        bus.FIFO_FULL = 1'b1;
        @(posedge CLK);
        #1;
        bus.FIFO_FULL = 1'b0;
        check("ovf_set", bus.ERR_OVERFLOW, 1);
        repeat (3) @(posedge CLK);
        #1;
        check("ovf_sticky", bus.ERR_OVERFLOW, 1);
        check("ovf_still_locked", bus.LOCKED, 1);
        bus.FIFO_FULL = 1'b1;
        send_cfg(8);
        bus.FIFO_FULL = 1'b0;
        check("ovf_cleared_by_cfg", bus.ERR_OVERFLOW, 0);
        check("cfg8_delay", bus.DLY_DELAY, 8);
        @(negedge CLK);
        count_until(0, 50, n);  check("cfg8_flush_len", n, 4);

        // Reset pulse in the middle of FILL.
        repeat (3) @(negedge CLK);
        RESETN = 1'b0;
        @(posedge CLK);
        #1;
        RESETN = 1'b1;
        check("mid_rst_delay", bus.DLY_DELAY, DEFAULT_DELAY);
        check("mid_rst_busy", bus.BUSY, 1);
        check("mid_rst_dly_resetn", bus.DLY_RESETN, 0);
        check("mid_rst_fifo_rst", bus.FIFO_RST, 1);
        check("mid_rst_ovf", bus.ERR_OVERFLOW, 0);
        @(negedge CLK);
        count_until(0, 50, n);  check("relaunch_flush_len", n, 4);
        count_until(1, 50, n);  check("relaunch_lock_lat", n, 2);

        repeat (5) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
